// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter and related schedulers.
// rr_pick is the behavioural form of the round-robin search done by rr_pick_comb.
package fifo_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int unsigned RR_MAX_REQ = 16;
  localparam int unsigned RR_IDX_W   = 4;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit at or above ptr, wrapping at n (n <= RR_MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                       input logic [RR_IDX_W-1:0]   ptr,
                                       input int unsigned           n);
    rr_pick_t    r;
    int unsigned k;
    r = '{found: 1'b0, idx: '0};
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && !r.found && req[k[RR_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = k[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer streams plus FIFO write-side signals of the write arbiter.
// master = arbiter side, slave = producers and FIFO.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        i_req_valid;
  logic [N_REQ*DATA_W-1:0] i_req_data;
  logic [N_REQ-1:0]        i_req_last;
  logic [N_REQ-1:0]        o_req_ready;
  logic                    o_grant_valid;
  logic [ID_W-1:0]         o_grant_id;
  logic                    o_wren;
  logic [DATA_W-1:0]       o_wrdata;
  logic                    i_full;
  logic                    i_alm_full;

  modport master (
    input  i_req_valid, i_req_data, i_req_last, i_full, i_alm_full,
    output o_req_ready, o_grant_valid, o_grant_id, o_wren, o_wrdata
  );

  modport slave (
    output i_req_valid, i_req_data, i_req_last, i_full, i_alm_full,
    input  o_req_ready, o_grant_valid, o_grant_id, o_wren, o_wrdata
  );

endinterface

// File: rtl/rr_pick_comb.sv
// Combinational round-robin search: rotate requests so ptr_i is bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick_comb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'((v >= N) ? v - N : v);
  endfunction

  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req_i[wrap(int'(ptr_i) + j)];
    end
    off = '0;
    for (int j = N-1; j >= 0; j--) begin
      if (rot[j]) off = IW'(j);
    end
    found_o = |rot;
    idx_o   = wrap(int'(ptr_i) + int'(off));
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ bursty producers.
// One write may be in flight, so ready also looks at alm_full while o_wren is high.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              wren_q, wren_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              can_accept;
  logic [N_REQ-1:0]  ready_c;

  rr_pick_comb #(.N(N_REQ)) u_pick (
    .req_i   (bus.i_req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_id_q == ID_W'(k)) begin
        sel_valid = bus.i_req_valid[k];
        sel_last  = bus.i_req_last[k];
        sel_data  = bus.i_req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign can_accept = !bus.i_full && !(wren_q && bus.i_alm_full);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    wren_d     = 1'b0;
    wrdata_d   = wrdata_q;
    ready_c    = '0;
    unique case (state_q)
      ARB: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        ready_c[grant_id_q] = can_accept;
        if (sel_valid && can_accept) begin
          wren_d     = 1'b1;
          wrdata_d   = sel_data;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (sel_last || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d  = ARB;
            rr_ptr_d = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      wren_q     <= 1'b0;
      wrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      wren_q     <= wren_d;
      wrdata_q   <= wrdata_d;
    end
  end

  assign bus.o_req_ready   = ready_c;
  assign bus.o_grant_valid = (state_q == BURST);
  assign bus.o_grant_id    = grant_id_q;
  assign bus.o_wren        = wren_q;
  assign bus.o_wrdata      = wrdata_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues, a 16-deep FIFO occupancy
// model and a write scoreboard filled in the expected arrival order.
module tb_fifo_wr_arbiter;
  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(NR), .DATA_W(DW)) bus ();

  fifo_wr_arbiter #(.N_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] pq [NR][$];
  logic [7:0] exp_q [$];
  int         acc_log [$];
  int         acc_cyc [$];
  logic [3:0] hold  = '0;
  logic       rd_en = 1'b1;
  int         fcnt  = 0;
  int         cyc   = 0;
  int         wr_cnt = 0;
  int         wr_base;

  always @(posedge clk) begin
    fcnt <= fcnt + (bus.o_wren ? 1 : 0) - ((rd_en && fcnt > 0) ? 1 : 0);
  end
  assign bus.i_full     = (fcnt >= DEPTH);
  assign bus.i_alm_full = (fcnt >= DEPTH - 1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_wren) begin
      wr_cnt++;
      check("wr_not_full", 32'(bus.i_full), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL wr_unexpected: observed %0h expected no write", bus.o_wrdata);
      end else begin
        check("wr_data", 32'(bus.o_wrdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive();
    logic [NR-1:0]    v, l;
    logic [NR*DW-1:0] d;
    logic [8:0]       b;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < NR; k++) begin
      if (pq[k].size() > 0 && !hold[k]) begin
        b = pq[k][0];
        v[k] = 1'b1;
        l[k] = b[8];
        d[k*DW +: DW] = b[7:0];
      end
    end
    bus.i_req_valid = v;
    bus.i_req_last  = l;
    bus.i_req_data  = d;
  endtask

  task automatic tick();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = bus.i_req_valid & bus.o_req_ready;
    check("ready_onehot", 32'($onehot0(bus.o_req_ready)), 32'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (acc[k]) begin
        void'(pq[k].pop_front());
        acc_log.push_back(k);
        acc_cyc.push_back(cyc);
      end
    end
    cyc++;
    drive();
  endtask

  task automatic push_beat(input int k, input logic [7:0] d, input logic l);
    pq[k].push_back({l, d});
  endtask

  function automatic bit queues_empty();
    int s;
    s = 0;
    for (int k = 0; k < NR; k++) s += pq[k].size();
    return s == 0;
  endfunction

  task automatic run_idle(input string tag);
    int n;
    n = 0;
    while (!(queues_empty() && !bus.o_grant_valid && !bus.o_wren && exp_q.size() == 0) && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req_valid = '0;
    bus.i_req_last  = '0;
    bus.i_req_data  = '0;

    // Reset values while rst is held
    @(posedge clk); @(posedge clk); #1;
    check("rst_wren",    32'(bus.o_wren),        32'd0);
    check("rst_wrdata",  32'(bus.o_wrdata),      32'd0);
    check("rst_gvalid",  32'(bus.o_grant_valid), 32'd0);
    check("rst_gid",     32'(bus.o_grant_id),    32'd0);
    check("rst_ready",   32'(bus.o_req_ready),   32'd0);
    rst = 1'b0;

    // Reset mid-burst with a write in flight
    push_beat(1, 8'h90, 1'b0); push_beat(1, 8'h91, 1'b0); push_beat(1, 8'h92, 1'b1);
    drive();
    tick();
    check("mid_gid",    32'(bus.o_grant_id),    32'd1);
    check("mid_gvalid", 32'(bus.o_grant_valid), 32'd1);
    tick();
    check("mid_wren_before", 32'(bus.o_wren),   32'd1);
    check("mid_data_before", 32'(bus.o_wrdata), 32'h90);
    #1 rst = 1'b1;
    #1;
    check("rstmid_wren",   32'(bus.o_wren),        32'd0);
    check("rstmid_gvalid", 32'(bus.o_grant_valid), 32'd0);
    check("rstmid_ready",  32'(bus.o_req_ready),   32'd0);
    pq[1].delete();
    drive();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin fairness, single-beat bursts
    acc_log.delete(); acc_cyc.delete();
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < NR; k++) begin
        push_beat(k, 8'(16 * k + n), 1'b1);
        exp_q.push_back(8'(16 * k + n));
      end
    end
    drive();
    run_idle("rr_idle");
    check("rr_count", 32'(acc_log.size()), 32'd8);
    for (int i = 0; i < acc_log.size() && i < 8; i++) begin
      check("rr_order", 32'(acc_log[i]), 32'(i % NR));
      if (i > 0) check("rr_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
    end

    // MAX_BURST cut: producer 2 never sets last, producer 1 joins
    acc_log.delete();
    for (int n = 0; n < 12; n++) push_beat(2, 8'(8'hA0 + n), 1'b0);
    for (int n = 0; n < 4; n++) exp_q.push_back(8'(8'hA0 + n));
    exp_q.push_back(8'h50); exp_q.push_back(8'h51);
    for (int n = 4; n < 12; n++) exp_q.push_back(8'(8'hA0 + n));
    drive();
    tick();
    check("cut_first_gid", 32'(bus.o_grant_id), 32'd2);
    push_beat(1, 8'h50, 1'b0); push_beat(1, 8'h51, 1'b1);
    drive();
    run_idle("cut_idle");
    check("cut_count", 32'(acc_log.size()), 32'd14);
    if (acc_log.size() == 14) begin
      check("cut_beat4_owner", 32'(acc_log[3]), 32'd2);
      check("cut_p1_first",    32'(acc_log[4]), 32'd1);
      check("cut_resume",      32'(acc_log[6]), 32'd2);
    end

    // Full back-pressure: no reads, producer 0 streams 20 beats
    begin
      int n;
      n = 0;
      while (fcnt != 0 && n < 20) begin tick(); n++; end
    end
    rd_en = 1'b0;
    check("full_start_empty", 32'(fcnt), 32'd0);
    wr_base = wr_cnt;
    for (int n = 0; n < 20; n++) begin
      push_beat(0, 8'(8'hC0 + n), 1'(n == 19));
      exp_q.push_back(8'(8'hC0 + n));
    end
    drive();
    repeat (60) tick();
    check("full_writes16", 32'(wr_cnt - wr_base), 32'd16);
    check("full_occ",      32'(fcnt),             32'd16);
    check("full_flag",     32'(bus.i_full),       32'd1);
    check("full_ready",    32'(bus.o_req_ready),  32'd0);
    check("full_wren",     32'(bus.o_wren),       32'd0);
    check("full_gvalid",   32'(bus.o_grant_valid),32'd1);
    rd_en = 1'b1;
    run_idle("full_idle");
    check("full_writes20", 32'(wr_cnt - wr_base), 32'd20);

    // Mid-burst stall of producer 3 while producer 0 waits
    push_beat(3, 8'hE0, 1'b0); push_beat(3, 8'hE1, 1'b0); push_beat(3, 8'hE2, 1'b1);
    push_beat(0, 8'h0F, 1'b1);
    exp_q.push_back(8'hE0); exp_q.push_back(8'hE1); exp_q.push_back(8'hE2); exp_q.push_back(8'h0F);
    drive();
    tick();
    check("stall_gid", 32'(bus.o_grant_id), 32'd3);
    tick();
    check("stall_first_acc", 32'(acc_log[acc_log.size()-1]), 32'd3);
    hold[3] = 1'b1;
    drive();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_wren",   32'(bus.o_wren),        32'd0);
      check("stall_gid_h",  32'(bus.o_grant_id),    32'd3);
      check("stall_gvalid", 32'(bus.o_grant_valid), 32'd1);
      check("stall_wrdata", 32'(bus.o_wrdata),      32'hE0);
    end
    hold[3] = 1'b0;
    drive();
    run_idle("stall_idle");

    // Wrap-around: producer 3 finishes, then 0 and 2 request together
    push_beat(3, 8'h33, 1'b1);
    exp_q.push_back(8'h33);
    drive();
    run_idle("wrap_p3_idle");
    push_beat(0, 8'h44, 1'b1); push_beat(2, 8'h66, 1'b1);
    exp_q.push_back(8'h44); exp_q.push_back(8'h66);
    drive();
    tick();
    check("wrap_gid",    32'(bus.o_grant_id),    32'd0);
    check("wrap_gvalid", 32'(bus.o_grant_valid), 32'd1);
    run_idle("wrap_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
